l1_fill_merge_buffer: RTL and testbench

Single-entry write-miss buffer for the L1 data cache. It captures byte-masked CPU word writes to a missing line and issues one L2 line fill. It then overlays the captured bytes on the returned fill data and presents the merged line to the cache array.
Generalises the cache write-merge datapath in several ways:
- parametrised word width and line length;
- writes to the same line coalesce while the fill is outstanding;
- fill and write merges in the same cycle are resolved per byte instead of by a single mux select.

---
 rtl/l1_fill_merge_buffer.sv | 120 ++++++++++++
 tb/tb_l1_fill_merge_buffer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_fill_merge_buffer.sv
// rtl/l1_fill_merge_buffer.sv - single-entry L1 write-miss buffer with per-byte fill merge
// Captures masked word writes to one missing line, requests an L2 fill, overlays captured bytes on the fill.

module l1_fill_merge_buffer #(
   parameter  int WORD_BITS      = 16,
   parameter  int WORDS_PER_LINE = 8,
   parameter  int LINE_ADDR_BITS = 12,
   localparam int BYTES_PER_WORD = WORD_BITS / 8,
   localparam int OFFSET_BITS    = $clog2(WORDS_PER_LINE),
   localparam int LINE_BITS      = WORD_BITS * WORDS_PER_LINE,
   localparam int LINE_BYTES     = LINE_BITS / 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      wr_valid,
   output logic                      wr_ready,
   input  logic [LINE_ADDR_BITS-1:0] wr_line_addr,
   input  logic [OFFSET_BITS-1:0]    wr_offset,
   input  logic [BYTES_PER_WORD-1:0] wr_wmask,
   input  logic [WORD_BITS-1:0]      wr_wdata,
   output logic                      fill_req,
   output logic [LINE_ADDR_BITS-1:0] fill_addr,
   input  logic                      fill_valid,
   input  logic [LINE_BITS-1:0]      fill_rdata,
   output logic                      line_valid,
   input  logic                      line_ready,
   output logic [LINE_ADDR_BITS-1:0] line_addr,
   output logic [LINE_BITS-1:0]      line_data,
   output logic                      busy
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] COLLECT = 2'd1;
   localparam logic [1:0] MERGED  = 2'd2;

   logic [1:0]                state_q, state_d;
   logic [LINE_ADDR_BITS-1:0] addr_q, addr_d;
   logic [LINE_BITS-1:0]      data_q, data_d;
   logic [LINE_BYTES-1:0]     bmask_q, bmask_d;

   logic                      wr_fire;
   logic                      fill_fire;
   logic [LINE_BYTES-1:0]     wr_ben;
   logic [LINE_BITS-1:0]      wr_line;

   always_comb begin
      wr_ready = (state_q == IDLE) ||
                 ((state_q == COLLECT) && (wr_line_addr == addr_q));
   end

   assign wr_fire   = wr_valid && wr_ready;
   assign fill_fire = (state_q == COLLECT) && fill_valid;
   assign wr_line   = {WORDS_PER_LINE{wr_wdata}};

   // Expand the word-level write onto line byte lanes.
   always_comb begin
      wr_ben = '0;
      for (int w = 0; w < WORDS_PER_LINE; w++) begin
         for (int k = 0; k < BYTES_PER_WORD; k++) begin
            wr_ben[w*BYTES_PER_WORD + k] = wr_fire &&
               (wr_offset == OFFSET_BITS'(w)) && wr_wmask[k];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      bmask_d = bmask_q;
      case (state_q)
         IDLE: begin
            if (wr_fire) begin
               addr_d  = wr_line_addr;
               state_d = COLLECT;
            end
         end
         COLLECT: begin
            if (fill_valid) state_d = MERGED;
         end
         MERGED: begin
            if (line_ready) begin
               bmask_d = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // A same-cycle write beats fill data; fill only lands on bytes never written.
      for (int b = 0; b < LINE_BYTES; b++) begin
         if (wr_ben[b])
            data_d[8*b +: 8] = wr_line[8*b +: 8];
         else if (fill_fire && !bmask_q[b])
            data_d[8*b +: 8] = fill_rdata[8*b +: 8];
      end
      bmask_d = bmask_d | wr_ben;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         bmask_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         bmask_q <= bmask_d;
      end
   end

   assign fill_req   = (state_q == COLLECT);
   assign fill_addr  = addr_q;
   assign line_valid = (state_q == MERGED);
   assign line_addr  = addr_q;
   assign line_data  = data_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_l1_fill_merge_buffer.sv
// tb/tb_l1_fill_merge_buffer.sv - scoreboard bench for l1_fill_merge_buffer
// Byte-level reference model feeds an expected-line queue; a monitor pops it on every line handshake.

module tb_l1_fill_merge_buffer;

   localparam int WB  = 16;
   localparam int WPL = 8;
   localparam int LAB = 12;
   localparam int BPW = 2;
   localparam int OFB = 3;
   localparam int LB  = 128;
   localparam int NBY = 16;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           wr_valid = 1'b0;
   logic           wr_ready;
   logic [LAB-1:0] wr_line_addr = '0;
   logic [OFB-1:0] wr_offset = '0;
   logic [BPW-1:0] wr_wmask = '0;
   logic [WB-1:0]  wr_wdata = '0;
   logic           fill_req;
   logic [LAB-1:0] fill_addr;
   logic           fill_valid = 1'b0;
   logic [LB-1:0]  fill_rdata = '0;
   logic           line_valid;
   logic           line_ready = 1'b1;
   logic [LAB-1:0] line_addr;
   logic [LB-1:0]  line_data;
   logic           busy;

   l1_fill_merge_buffer #(.WORD_BITS(WB), .WORDS_PER_LINE(WPL), .LINE_ADDR_BITS(LAB)) dut (
      .clk(clk), .reset(reset),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_line_addr(wr_line_addr),
      .wr_offset(wr_offset), .wr_wmask(wr_wmask), .wr_wdata(wr_wdata),
      .fill_req(fill_req), .fill_addr(fill_addr), .fill_valid(fill_valid), .fill_rdata(fill_rdata),
      .line_valid(line_valid), .line_ready(line_ready), .line_addr(line_addr), .line_data(line_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [LAB-1:0] addr;
      logic [LB-1:0]  data;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   fill_rises = 0;
   logic fill_req_prev = 1'b0;

   bit             m_open = 1'b0;
   logic [LAB-1:0] m_addr;
   bit             m_mask [NBY];
   logic [7:0]     m_byte [NBY];

   task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [LB-1:0] rep(input logic [WB-1:0] w);
      return {WPL{w}};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_write(input logic [LAB-1:0] a, input int off, input logic [BPW-1:0] m,
                              input logic [WB-1:0] d);
      if (!m_open) begin
         m_open = 1'b1;
         m_addr = a;
         for (int b = 0; b < NBY; b++) m_mask[b] = 1'b0;
      end
      for (int k = 0; k < BPW; k++) begin
         if (m[k]) begin
            m_mask[off*BPW + k] = 1'b1;
            m_byte[off*BPW + k] = d[8*k +: 8];
         end
      end
   endtask

   task automatic model_fill(input logic [LB-1:0] rd);
      exp_t e;
      if (m_open) begin
         e.addr = m_addr;
         for (int b = 0; b < NBY; b++)
            e.data[8*b +: 8] = m_mask[b] ? m_byte[b] : rd[8*b +: 8];
         exp_q.push_back(e);
         m_open = 1'b0;
      end
   endtask

   task automatic wr(input logic [LAB-1:0] a, input int off, input logic [BPW-1:0] m,
                     input logic [WB-1:0] d);
      bit acc;
      acc = 1'b0;
      wr_valid = 1'b1; wr_line_addr = a; wr_offset = off[OFB-1:0]; wr_wmask = m; wr_wdata = d;
      for (int t = 0; t < 64 && !acc; t++) begin
         @(negedge clk);
         acc = wr_ready;
         step();
      end
      wr_valid = 1'b0;
      if (!acc) begin
         n_cmp++; n_err++;
         $display("FAIL wr_timeout: write to %0h never accepted, required accept", a);
      end else begin
         model_write(a, off, m, d);
      end
   endtask

   task automatic fill_pulse(input logic [LB-1:0] rd);
      fill_valid = 1'b1; fill_rdata = rd;
      model_fill(rd);
      step();
      fill_valid = 1'b0;
   endtask

   task automatic wr_fill(input logic [LAB-1:0] a, input int off, input logic [BPW-1:0] m,
                          input logic [WB-1:0] d, input logic [LB-1:0] rd);
      wr_valid = 1'b1; wr_line_addr = a; wr_offset = off[OFB-1:0]; wr_wmask = m; wr_wdata = d;
      fill_valid = 1'b1; fill_rdata = rd;
      @(negedge clk);
      chk("simul_wr_ready", LB'(wr_ready), LB'(1));
      model_write(a, off, m, d);
      model_fill(rd);
      step();
      wr_valid = 1'b0; fill_valid = 1'b0;
   endtask

   task automatic drain();
      bit idle;
      idle = 1'b0;
      for (int t = 0; t < 64 && !idle; t++) begin
         @(negedge clk);
         idle = !busy;
         if (!idle) step();
      end
      if (!idle) begin
         n_cmp++; n_err++;
         $display("FAIL drain_timeout: busy=%0b required 0", busy);
      end
      step();
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (fill_req && !fill_req_prev) fill_rises++;
            if (line_valid && line_ready) begin
               if (exp_q.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL unexpected_line: addr %0h data %0h, required no line", line_addr, line_data);
               end else begin
                  e = exp_q.pop_front();
                  chk("line_addr", LB'(line_addr), LB'(e.addr));
                  chk("line_data", line_data, e.data);
               end
            end
         end
         fill_req_prev = fill_req;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      logic [LB-1:0] e1;
      logic [LB-1:0] rd;
      exp_t          last;
      int            r0;
      int            nw;
      int            off;
      logic [LAB-1:0] a;

      // Reset and idle
      repeat (3) step();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rst_wr_ready", LB'(wr_ready), LB'(1));
         chk("rst_fill_req", LB'(fill_req), LB'(0));
         chk("rst_line_valid", LB'(line_valid), LB'(0));
         chk("rst_busy", LB'(busy), LB'(0));
         chk("rst_line_data", line_data, '0);
         chk("rst_addrs", LB'({fill_addr, line_addr}), '0);
         step();
      end

      // Single partial write
      wr(12'h123, 3, 2'b01, 16'hBEEF);
      @(negedge clk);
      chk("lat_fill_req", LB'(fill_req), LB'(1));
      chk("fill_addr", LB'(fill_addr), LB'(12'h123));
      step();
      fill_pulse(rep(16'h1111));
      @(negedge clk);
      e1 = rep(16'h1111);
      e1[63:48] = 16'h11EF;
      chk("partial_line_valid", LB'(line_valid), LB'(1));
      chk("partial_line_data", line_data, e1);
      step();
      @(negedge clk);
      chk("partial_one_cycle", LB'(line_valid), LB'(0));
      chk("partial_idle", LB'(busy), LB'(0));
      step();

      // Coalescing
      r0 = fill_rises;
      wr(12'h040, 0, 2'b11, 16'hAAAA);
      wr(12'h040, 7, 2'b10, 16'hCC00);
      wr(12'h040, 0, 2'b01, 16'h0055);
      step();
      fill_pulse('0);
      @(negedge clk);
      e1 = '0;
      e1[15:0] = 16'hAA55;
      e1[127:112] = 16'hCC00;
      chk("coalesce_data", line_data, e1);
      drain();
      chk("coalesce_one_req", LB'(fill_rises - r0), LB'(1));

      // Address conflict
      wr(12'h040, 2, 2'b11, 16'h5A5A);
      wr_valid = 1'b1; wr_line_addr = 12'h041; wr_offset = 3'd6; wr_wmask = 2'b10; wr_wdata = 16'h7700;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("conflict_collect_wr_ready", LB'(wr_ready), LB'(0));
         step();
      end
      line_ready = 1'b0;
      fill_pulse({$urandom, $urandom, $urandom, $urandom});
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("conflict_merged_wr_ready", LB'(wr_ready), LB'(0));
         step();
      end
      line_ready = 1'b1;
      begin : conflict_wait
         bit acc;
         acc = 1'b0;
         for (int t = 0; t < 16 && !acc; t++) begin
            @(negedge clk);
            if (wr_ready) begin
               acc = 1'b1;
               chk("conflict_accept_in_idle", LB'(busy), LB'(0));
            end
            step();
         end
         wr_valid = 1'b0;
         if (!acc) begin
            n_cmp++; n_err++;
            $display("FAIL conflict_timeout: wr_ready=0 required 1");
         end else begin
            model_write(12'h041, 6, 2'b10, 16'h7700);
         end
      end
      @(negedge clk);
      chk("conflict_new_fill_addr", LB'(fill_addr), LB'(12'h041));
      chk("conflict_new_fill_req", LB'(fill_req), LB'(1));
      step();
      fill_pulse({$urandom, $urandom, $urandom, $urandom});
      drain();

      // Simultaneous write and fill, first write has an empty mask
      wr(12'h2A0, 4, 2'b00, 16'h9999);
      step();
      wr_fill(12'h2A0, 5, 2'b11, 16'h1234, rep(16'hFFFF));
      @(negedge clk);
      e1 = rep(16'hFFFF);
      e1[95:80] = 16'h1234;
      chk("simul_line_data", line_data, e1);
      drain();

      // Backpressure in MERGED
      wr(12'h3C3, 1, 2'b10, 16'hAB00);
      line_ready = 1'b0;
      fill_pulse({$urandom, $urandom, $urandom, $urandom});
      last = exp_q[exp_q.size()-1];
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("bp_line_valid", LB'(line_valid), LB'(1));
         chk("bp_line_data", line_data, last.data);
         chk("bp_wr_ready", LB'(wr_ready), LB'(0));
         step();
      end
      line_ready = 1'b1;
      drain();

      // Reset while collecting
      wr(12'h155, 0, 2'b11, 16'h7777);
      reset = 1'b1;
      step();
      reset = 1'b0;
      m_open = 1'b0;
      @(negedge clk);
      chk("midrst_fill_req", LB'(fill_req), LB'(0));
      chk("midrst_busy", LB'(busy), LB'(0));
      step();
      fill_pulse(rep(16'h3333));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("midrst_no_line", LB'(line_valid), LB'(0));
         step();
      end

      // Randomized transactions
      for (int n = 0; n < 40; n++) begin
         a  = LAB'($urandom_range(0, 4095));
         nw = $urandom_range(1, 4);
         for (int j = 0; j < nw; j++)
            wr(a, $urandom_range(0, 7), BPW'($urandom_range(0, 3)), WB'($urandom));
         repeat ($urandom_range(0, 3)) step();
         rd = {$urandom, $urandom, $urandom, $urandom};
         line_ready = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 3) == 0) begin
            off = $urandom_range(0, 7);
            wr_fill(a, off, BPW'($urandom_range(0, 3)), WB'($urandom), rd);
         end else begin
            fill_pulse(rd);
         end
         if (!line_ready) begin
            repeat ($urandom_range(1, 3)) step();
            line_ready = 1'b1;
         end
         drain();
      end

      repeat (2) step();
      chk("queue_empty", LB'(exp_q.size()), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
